// File: rtl/spi_reg_slave.sv
`default_nettype none
// ============================================================================
// spi_reg_slave : SPI mode-0 slave register file, {RW,ADDR[6:0]} + data frames
// Revision      : 1.0
// ============================================================================
module spi_reg_slave #(
   parameter int          NUM_REGS    = 64,
   parameter logic [7:0]  RESET_VAL   = 8'h00,
   parameter int          SYNC_STAGES = 2
) (
   input  logic       I_clk,
   input  logic       I_rst_n,
   input  logic       I_sclk,
   input  logic       I_cs_n,
   input  logic       I_mosi,
   output logic       O_miso,
   output logic       O_miso_oe,
   output logic       O_wr_stb,
   output logic [6:0] O_wr_addr,
   output logic [7:0] O_wr_data,
   output logic       O_abort,
   output logic       O_addr_err,
   input  logic [6:0] I_rd_addr,
   output logic [7:0] O_rd_data
);

   localparam int         c_aw       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [7:0] c_num_regs = 8'(NUM_REGS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t r_state, w_state_nxt;

   logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
   logic r_sclk_prev, r_cs_prev;
   logic w_sclk, w_cs, w_mosi;
   logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

   logic [2:0] r_bit_cnt;
   logic [7:0] r_shift;
   logic [7:0] r_tx;
   logic       r_rw;
   logic [6:0] r_addr;
   logic       r_in_range;
   logic [7:0] r_regs [NUM_REGS];

   logic       w_shift_en, w_cmd_done, w_data_done, w_tx_shift, w_abort, w_clr_cnt;
   logic [6:0] w_cmd_addr;
   logic       w_cmd_in_range, w_wr_commit;
   logic [7:0] w_rx_byte;

   // Chip select idles high so the synchronizer resets to the deasserted level.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_sclk_prev <= 1'b0;
         r_cs_prev   <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], I_sclk};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], I_cs_n};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], I_mosi};
         r_sclk_prev <= w_sclk;
         r_cs_prev   <= w_cs;
      end
   end

   assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs        = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
   assign w_sclk_rise =  w_sclk & ~r_sclk_prev;
   assign w_sclk_fall = ~w_sclk &  r_sclk_prev;
   assign w_cs_rise   =  w_cs   & ~r_cs_prev;
   assign w_cs_fall   = ~w_cs   &  r_cs_prev;

   assign w_rx_byte      = {r_shift[6:0], w_mosi};
   assign w_cmd_addr     = {r_shift[5:0], w_mosi};
   assign w_cmd_in_range = ({1'b0, w_cmd_addr} < c_num_regs);
   assign w_wr_commit    = w_data_done & r_rw & r_in_range;

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_shift_en  = 1'b0;
      w_cmd_done  = 1'b0;
      w_data_done = 1'b0;
      w_tx_shift  = 1'b0;
      w_abort     = 1'b0;
      w_clr_cnt   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_cs_fall) begin
               w_state_nxt = ST_ADDR;
               w_clr_cnt   = 1'b1;
            end
         end
         ST_ADDR: begin
            if (w_cs_rise) begin
               w_state_nxt = ST_IDLE;
               w_abort     = (r_bit_cnt != 3'd0);
               w_clr_cnt   = 1'b1;
            end else if (w_sclk_rise) begin
               w_shift_en = 1'b1;
               if (r_bit_cnt == 3'd7) begin
                  w_cmd_done  = 1'b1;
                  w_state_nxt = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            // A final data bit arriving with CS rising still completes the frame.
            if (w_sclk_rise && (r_bit_cnt == 3'd7)) begin
               w_shift_en  = 1'b1;
               w_data_done = 1'b1;
               w_state_nxt = w_cs_rise ? ST_IDLE : ST_ADDR;
               w_clr_cnt   = w_cs_rise;
            end else if (w_cs_rise) begin
               w_state_nxt = ST_IDLE;
               w_abort     = 1'b1;
               w_clr_cnt   = 1'b1;
            end else begin
               w_shift_en = w_sclk_rise;
               // The fall closing the command byte must not consume the preloaded MSB.
               w_tx_shift = w_sclk_fall && (r_bit_cnt != 3'd0);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_bit_cnt  <= 3'd0;
         r_shift    <= 8'h00;
         r_tx       <= 8'h00;
         r_rw       <= 1'b0;
         r_addr     <= 7'd0;
         r_in_range <= 1'b0;
         O_wr_stb   <= 1'b0;
         O_wr_addr  <= 7'd0;
         O_wr_data  <= 8'h00;
         O_abort    <= 1'b0;
         O_addr_err <= 1'b0;
      end else begin
         O_wr_stb   <= 1'b0;
         O_abort    <= w_abort;
         O_addr_err <= 1'b0;

         if (w_clr_cnt) begin
            r_bit_cnt <= 3'd0;
         end else if (w_shift_en) begin
            r_bit_cnt <= 3'(r_bit_cnt + 3'd1);
         end

         if (w_shift_en) begin
            r_shift <= w_rx_byte;
         end

         if (w_cmd_done) begin
            r_rw       <= r_shift[6];
            r_addr     <= w_cmd_addr;
            r_in_range <= w_cmd_in_range;
            if (!r_shift[6]) begin
               r_tx       <= w_cmd_in_range ? r_regs[w_cmd_addr[c_aw-1:0]] : 8'h00;
               O_addr_err <= ~w_cmd_in_range;
            end
         end else if (w_tx_shift) begin
            r_tx <= {r_tx[6:0], 1'b0};
         end

         if (w_data_done && r_rw) begin
            if (r_in_range) begin
               O_wr_stb  <= 1'b1;
               O_wr_addr <= r_addr;
               O_wr_data <= w_rx_byte;
            end else begin
               O_addr_err <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= RESET_VAL;
         end
      end else if (w_wr_commit) begin
         r_regs[r_addr[c_aw-1:0]] <= w_rx_byte;
      end
   end

   // Same-cycle SPI writes are seen here one cycle later (old value first).
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         O_rd_data <= 8'h00;
      end else if ({1'b0, I_rd_addr} < c_num_regs) begin
         O_rd_data <= r_regs[I_rd_addr[c_aw-1:0]];
      end else begin
         O_rd_data <= 8'h00;
      end
   end

   assign O_miso_oe = (r_state == ST_DATA) && !r_rw;
   assign O_miso    = O_miso_oe ? r_tx[7] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_slave.sv
`default_nettype none
// ============================================================================
// tb_spi_reg_slave : directed SPI frame bench for spi_reg_slave
// Revision         : 1.0
// ============================================================================
module tb_spi_reg_slave;

   localparam int HALF = 160;

   logic       I_clk = 1'b0;
   logic       I_rst_n = 1'b0;
   logic       I_sclk = 1'b0;
   logic       I_cs_n = 1'b1;
   logic       I_mosi = 1'b0;
   logic [6:0] I_rd_addr = 7'd0;
   logic       O_miso, O_miso_oe, O_wr_stb, O_abort, O_addr_err;
   logic [6:0] O_wr_addr;
   logic [7:0] O_wr_data, O_rd_data;

   spi_reg_slave #(
      .NUM_REGS    (64),
      .RESET_VAL   (8'h00),
      .SYNC_STAGES (2)
   ) dut (
      .I_clk      (I_clk),
      .I_rst_n    (I_rst_n),
      .I_sclk     (I_sclk),
      .I_cs_n     (I_cs_n),
      .I_mosi     (I_mosi),
      .O_miso     (O_miso),
      .O_miso_oe  (O_miso_oe),
      .O_wr_stb   (O_wr_stb),
      .O_wr_addr  (O_wr_addr),
      .O_wr_data  (O_wr_data),
      .O_abort    (O_abort),
      .O_addr_err (O_addr_err),
      .I_rd_addr  (I_rd_addr),
      .O_rd_data  (O_rd_data)
   );

   always #10 I_clk = ~I_clk;

   int errors = 0;
   int checks = 0;
   int abort_cnt = 0;
   int err_cnt = 0;
   logic [14:0] stb_q [$];

   always @(negedge I_clk) begin
      if (O_wr_stb) stb_q.push_back({O_wr_addr, O_wr_data});
      if (O_abort) abort_cnt++;
      if (O_addr_err) err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic spi_bits(input logic [7:0] b, input int n,
                           output logic [7:0] rx, output logic [7:0] oe);
      rx = 8'h00;
      oe = 8'h00;
      for (int i = 7; i >= 8 - n; i--) begin
         I_mosi = b[i];
         #(HALF);
         rx[i] = O_miso;
         oe[i] = O_miso_oe;
         I_sclk = 1'b1;
         #(HALF);
         I_sclk = 1'b0;
      end
   endtask

   task automatic cs_low();
      @(negedge I_clk);
      I_cs_n = 1'b0;
      #(HALF);
   endtask

   task automatic cs_high();
      #(HALF);
      I_cs_n = 1'b1;
      #(HALF * 2);
   endtask

   task automatic frame(input logic [7:0] cmd, input logic [7:0] dat,
                        output logic [7:0] rx, output logic [7:0] oe_c, output logic [7:0] oe_d);
      logic [7:0] rx_c;
      cs_low();
      spi_bits(cmd, 8, rx_c, oe_c);
      spi_bits(dat, 8, rx, oe_d);
      cs_high();
   endtask

   task automatic fab_rd(input logic [6:0] a, output logic [7:0] d);
      @(negedge I_clk);
      I_rd_addr = a;
      @(negedge I_clk);
      d = O_rd_data;
   endtask

   initial begin
      logic [7:0] rx, oe_c, oe_d, rd;
      logic [6:0] burst [18] = '{7'h06, 7'h07, 7'h08, 7'h0B, 7'h0C, 7'h0D, 7'h0F, 7'h10, 7'h11,
                                 7'h12, 7'h13, 7'h14, 7'h15, 7'h16, 7'h17, 7'h18, 7'h1F, 7'h20};
      logic [6:0] untouched [5] = '{7'h09, 7'h0E, 7'h1E, 7'h21, 7'h3F};
      int base, ab0, er0;

      repeat (5) @(negedge I_clk);
      check("reset_outputs", {O_miso, O_miso_oe, O_wr_stb, O_abort, O_addr_err, O_wr_addr, O_wr_data, O_rd_data}, 0);
      I_rst_n = 1'b1;
      repeat (4) @(negedge I_clk);
      fab_rd(7'd1, rd);
      check("reset_reg1", rd, 8'h00);

      // SCLK activity with CS high must do nothing.
      for (int i = 0; i < 16; i++) begin
         I_mosi = 1'b1; #(HALF); I_sclk = ~I_sclk;
      end
      I_mosi = 1'b0;
      #(HALF * 2);
      check("cs_high_ignored", {stb_q.size(), abort_cnt, err_cnt}, 0);

      // Write reg[1] = 0x07
      frame(8'h81, 8'h07, rx, oe_c, oe_d);
      check("write_stb_count", stb_q.size(), 1);
      check("write_stb", (stb_q.size() > 0) ? stb_q[0] : 15'h7FFF, {7'h01, 8'h07});
      check("write_no_abort", abort_cnt, 0);
      check("write_oe_low", {oe_c, oe_d}, 16'h0000);

      // Readback reg[1]
      frame(8'h01, 8'h00, rx, oe_c, oe_d);
      check("read_miso", rx, 8'h07);
      check("read_oe", {oe_c, oe_d}, 16'h00FF);
      check("read_no_stb", stb_q.size(), 1);
      fab_rd(7'd1, rd);
      check("fabric_rd1", rd, 8'h07);

      // Streaming burst of 18 writes in one CS period
      base = stb_q.size();
      cs_low();
      for (int k = 0; k < 18; k++) begin
         spi_bits({1'b1, burst[k]}, 8, rx, oe_c);
         spi_bits(8'h07, 8, rx, oe_d);
      end
      cs_high();
      check("burst_stb_count", stb_q.size() - base, 18);
      for (int k = 0; k < 18; k++) begin
         check("burst_stb", (stb_q.size() > base + k) ? stb_q[base + k] : 15'h7FFF, {burst[k], 8'h07});
         fab_rd(burst[k], rd);
         check("burst_reg", rd, 8'h07);
      end
      for (int k = 0; k < 5; k++) begin
         fab_rd(untouched[k], rd);
         check("burst_untouched", rd, 8'h00);
      end
      check("burst_no_abort", abort_cnt, 0);

      // Abort: command plus 4 data bits
      base = stb_q.size();
      cs_low();
      spi_bits(8'h85, 8, rx, oe_c);
      spi_bits(8'hF0, 4, rx, oe_d);
      cs_high();
      check("abort_count", abort_cnt, 1);
      check("abort_no_stb", stb_q.size() - base, 0);
      fab_rd(7'd5, rd);
      check("abort_reg5", rd, 8'h00);
      frame(8'h85, 8'h3C, rx, oe_c, oe_d);
      fab_rd(7'd5, rd);
      check("after_abort_reg5", rd, 8'h3C);
      check("after_abort_stb", (stb_q.size() > base) ? stb_q[base] : 15'h7FFF, {7'h05, 8'h3C});

      // Out-of-range write then read
      base = stb_q.size();
      er0 = err_cnt;
      ab0 = abort_cnt;
      frame(8'hC5, 8'hAA, rx, oe_c, oe_d);
      check("oor_wr_err", err_cnt - er0, 1);
      check("oor_wr_no_stb", stb_q.size() - base, 0);
      fab_rd(7'd5, rd);
      check("oor_reg5_kept", rd, 8'h3C);
      fab_rd(7'h45, rd);
      check("oor_fabric_rd", rd, 8'h00);
      frame(8'h45, 8'hFF, rx, oe_c, oe_d);
      check("oor_rd_miso", rx, 8'h00);
      check("oor_rd_oe", oe_d, 8'hFF);
      check("oor_rd_err", err_cnt - er0, 2);
      check("oor_no_abort", abort_cnt - ab0, 0);

      // Reset after 11 bits of a write frame
      base = stb_q.size();
      cs_low();
      spi_bits(8'h82, 8, rx, oe_c);
      spi_bits(8'h55, 3, rx, oe_d);
      I_rst_n = 1'b0;
      @(negedge I_clk);
      I_cs_n = 1'b1;
      repeat (3) @(negedge I_clk);
      check("midreset_outputs", {O_miso, O_miso_oe, O_wr_stb, O_abort, O_addr_err, O_wr_addr, O_wr_data, O_rd_data}, 0);
      I_rst_n = 1'b1;
      repeat (4) @(negedge I_clk);
      check("midreset_no_stb", stb_q.size() - base, 0);
      fab_rd(7'd2, rd);
      check("midreset_reg2", rd, 8'h00);
      fab_rd(7'd1, rd);
      check("midreset_reg1_cleared", rd, 8'h00);
      frame(8'h82, 8'h55, rx, oe_c, oe_d);
      fab_rd(7'd2, rd);
      check("post_reset_reg2", rd, 8'h55);
      check("post_reset_stb", (stb_q.size() > base) ? stb_q[base] : 15'h7FFF, {7'h02, 8'h55});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_reg_slave.md
Name: spi_reg_slave

Overview:
- SPI slave register file: the device-side responder for the address/data byte stream our ADC-configuration sequencer sends through spi_module.
- Accepts 16-bit frames: command byte {RW, ADDR[6:0]}, then one data byte. Writes commit into an internal register map; reads return register contents on MISO.
- Used as the ADC register-map model in simulation and as a configurable SPI target in FPGA builds.
- Fabric side gets a write strobe and a registered read port.

Parameters:
- NUM_REGS, 64, number of 8-bit registers; valid addresses are 0..NUM_REGS-1 (max 128).
- RESET_VAL, 8'h00, reset value of every register.
- SYNC_STAGES, 2, synchronizer depth for SCLK, CS_n and MOSI (minimum 2).

Ports:
- I_clk  in  1  system clock, 50 MHz.
- I_rst_n  in  1  asynchronous, active-low reset.
- I_sclk  in  1  SPI clock, mode 0, at most I_clk/8.
- I_cs_n  in  1  SPI chip select, active low.
- I_mosi  in  1  SPI data in.
- O_miso  out  1  SPI data out.
- O_miso_oe  out  1  MISO output enable; high only during the data phase of a read.
- O_wr_stb  out  1  one-cycle pulse when a write commits.
- O_wr_addr  out  7  address of the committed write.
- O_wr_data  out  8  data of the committed write.
- O_abort  out  1  one-cycle pulse on an incomplete frame.
- O_addr_err  out  1  one-cycle pulse on access to an out-of-range address.
- I_rd_addr  in  7  fabric read address.
- O_rd_data  out  8  fabric read data, registered.

Behaviour:
- Reset:
  - All outputs 0.
  - Registers set to RESET_VAL.
  - State machine goes to IDLE, bit counter 0, shift registers 0.
- Synchronization and edge detection:
  - SCLK, CS_n and MOSI pass through SYNC_STAGES flops.
  - Edge detection uses the last synced value against the previous one.
  - All actions below occur on the I_clk cycle after the synced edge is detected.
- Shifting:
  - MOSI is sampled on synced SCLK rising edges, MSB first.
  - The MISO shifter advances on synced SCLK falling edges.
- States:
  - IDLE: O_miso_oe=0. Synced CS_n falling → ADDR, bit_cnt=0.
  - ADDR: each rise shifts one bit in and increments bit_cnt. On the 8th rise, latch rw=bit7 and addr=bits[6:0], reset bit_cnt, go to DATA.
    - If rw=0 and addr is in range: load the tx shifter with reg[addr] in that same cycle.
    - If rw=0 and addr is out of range: load 8'h00 and pulse O_addr_err.
  - DATA, read (rw=0):
    - O_miso_oe=1.
    - O_miso presents the tx MSB immediately and shifts on each of the next 7 falling edges.
    - On the 8th rise, return to ADDR (streaming).
  - DATA, write (rw=1):
    - On the 8th rise, if addr is in range: reg[addr] ← shifted byte, and O_wr_stb=1 for one cycle with O_wr_addr/O_wr_data valid in that cycle.
    - If addr is out of range: no write, pulse O_addr_err.
    - Return to ADDR.
- Streaming: consecutive frames inside one CS_n low period are allowed, and each pair is handled independently. A 36-byte burst therefore gives 18 accesses.
- CS_n rising edge:
  - In ADDR with bit_cnt=0, or in IDLE: go to IDLE silently.
  - In ADDR with bit_cnt≠0, or in DATA: no write, pulse O_abort, go to IDLE.
  - CS_n rising on the same cycle as the 8th DATA rise: the write commits first and O_abort is not raised.
- MISO idle value: O_miso=0 whenever O_miso_oe=0.
- Fabric read port: O_rd_data ← reg[I_rd_addr] one cycle after I_rd_addr is presented, or 8'h00 if out of range.
  - If an SPI write to the same address commits in the same cycle, O_rd_data shows the old value; the new value appears on the next cycle.
- Reset mid-frame: immediate return to the reset state. Partial data is discarded and no strobes are issued.
- SCLK edges while CS_n is high are ignored.

Test Plan:
- Write: CS low, send 0x81, 0x07, CS high → reg[1]=0x07; one O_wr_stb with O_wr_addr=1, O_wr_data=0x07; O_abort=0.
- Readback: after the write, send 0x01, 0x00 → O_miso_oe high for bits 9–16; MISO bits 9–16 = 0x07; no O_wr_stb. After CS high, fabric I_rd_addr=1 gives O_rd_data=0x07 one cycle later.
- Streaming burst: one CS low period carrying 18 pairs {0x80|a, 0x07} for a=0x06,0x07,0x08,0x0B..0x0D,0x0F..0x18,0x1F,0x20 → 18 strobes in order and each register =0x07; untouched registers stay RESET_VAL.
- Abort: send 0x85, then 4 data bits, then CS high → O_abort pulses once, reg[5] unchanged, no strobe. The next full frame 0x85, 0x3C writes 0x3C.
- Out of range (NUM_REGS=64):
  - Write 0xC5 (addr 0x45), 0xAA → O_addr_err pulse, no strobe, no register changes.
  - Read 0x45 → MISO shifts 0x00.
- Reset: assert I_rst_n low after 11 bits of the 0x82, 0x55 frame → reg[2]=RESET_VAL, all outputs 0. After release, a fresh frame 0x82, 0x55 writes correctly.
